// File: rtl/hicore_flush_queue_if.sv
// ============================================================================
// Module  : hicore_flush_queue_if
// Brief   : Producer/consumer handshake bundle for hicore_flush_queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HiCore_ISSUE2ALU_SIZE
`define HiCore_ISSUE2ALU_SIZE 64
`endif

interface hicore_flush_queue_if #(
    parameter int DW = `HiCore_ISSUE2ALU_SIZE
);
    logic          i_valid;
    logic          i_ready;
    logic          i_cancel;
    logic [DW-1:0] i_info;
    logic          o_valid;
    logic          o_ready;
    logic          o_cancel;
    logic [DW-1:0] o_info;

    // Queue side
    modport slave (
        input  i_valid, i_cancel, i_info, o_ready,
        output i_ready, o_valid, o_cancel, o_info
    );

    // Environment side (issue producer + ALU/LSU consumer)
    modport master (
        output i_valid, i_cancel, i_info, o_ready,
        input  i_ready, o_valid, o_cancel, o_info
    );
endinterface

`default_nettype wire

// File: rtl/hicore_flush_queue.sv
// ============================================================================
// Module  : hicore_flush_queue
// Brief   : In-order issue queue with per-entry cancel tag, soft flush,
//           hard kill, optional empty bypass, occupancy and almost-full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HiCore_ISSUE2ALU_SIZE
`define HiCore_ISSUE2ALU_SIZE 64
`endif

module hicore_flush_queue #(
    parameter int DW       = `HiCore_ISSUE2ALU_SIZE,
    parameter int DP       = 4,
    parameter int LOGDP    = 2,
    parameter int BYPASS   = 0,
    parameter int AFULL_TH = 3
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    hicore_flush_queue_if.slave     bus,
    input  wire logic               flush,
    input  wire logic               kill,
    output logic [LOGDP:0]          count,
    output logic                    almost_full
);

    localparam logic [LOGDP:0] c_afull_th = (LOGDP + 1)'(AFULL_TH);
    localparam logic [LOGDP:0] c_one      = (LOGDP + 1)'(1);

    logic [LOGDP:0]   r_wr_ptr;
    logic [LOGDP:0]   r_rd_ptr;
    logic [DP-1:0]    r_cancel;
    logic [DW-1:0]    r_mem [DP];

    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_wen;
    logic             w_ren;
    logic             w_push;
    logic             w_pop;
    logic [LOGDP-1:0] w_wr_idx;
    logic [LOGDP-1:0] w_rd_idx;
    logic [LOGDP:0]   w_wr_ptr_nxt;
    logic [LOGDP:0]   w_rd_ptr_nxt;

    assign w_wr_idx = r_wr_ptr[LOGDP-1:0];
    assign w_rd_idx = r_rd_ptr[LOGDP-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[LOGDP] != r_rd_ptr[LOGDP]) &&
                      (r_wr_ptr[LOGDP-1:0] == r_rd_ptr[LOGDP-1:0]);

    // Bypass is suppressed during kill so a killed cycle never shows a head.
    assign w_bypass = (BYPASS != 0) && w_empty && !kill;

    assign bus.i_ready  = !w_full;
    assign bus.o_valid  = w_bypass ? bus.i_valid : !w_empty;
    assign bus.o_info   = w_bypass ? bus.i_info : r_mem[w_rd_idx];
    assign bus.o_cancel = w_bypass ? (bus.i_cancel | flush) : r_cancel[w_rd_idx];

    assign w_wen = bus.i_valid && !w_full;
    assign w_ren = bus.o_valid && bus.o_ready;

    // A bypassed entry taken by the consumer never touches storage.
    assign w_push = w_wen && !(w_bypass && bus.o_ready);
    assign w_pop  = w_ren && !w_empty;

    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + c_one) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + c_one) : r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cancel <= '0;
        end else if (kill) begin
            // Collapse the queue onto the post-write pointer, dropping that write too.
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_wr_ptr_nxt;
            r_cancel <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (flush) begin
                r_cancel <= '1;
            end else if (w_push) begin
                r_cancel[w_wr_idx] <= bus.i_cancel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= bus.i_info;
        end
    end

    assign count       = r_wr_ptr - r_rd_ptr;
    assign almost_full = (count >= c_afull_th);

endmodule

`default_nettype wire

// File: tb/tb_hicore_flush_queue.sv
// ============================================================================
// Module  : tb_hicore_flush_queue
// Brief   : Three queue configurations on shared stimulus, checked each cycle
//           against an entry-list model of the queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hicore_flush_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       i_cancel;
    logic [7:0] i_info;
    logic       o_ready;
    logic       flush;
    logic       kill;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // dut0: DP=4 no bypass; dut1: DP=8 bypass; dut2: DP=8 no bypass
    hicore_flush_queue_if #(.DW(8)) bus0 ();
    hicore_flush_queue_if #(.DW(8)) bus1 ();
    hicore_flush_queue_if #(.DW(8)) bus2 ();

    logic [2:0] cnt0;
    logic [3:0] cnt1;
    logic [3:0] cnt2;
    logic       af0, af1, af2;

    assign bus0.i_valid = i_valid; assign bus0.i_cancel = i_cancel;
    assign bus0.i_info  = i_info;  assign bus0.o_ready  = o_ready;
    assign bus1.i_valid = i_valid; assign bus1.i_cancel = i_cancel;
    assign bus1.i_info  = i_info;  assign bus1.o_ready  = o_ready;
    assign bus2.i_valid = i_valid; assign bus2.i_cancel = i_cancel;
    assign bus2.i_info  = i_info;  assign bus2.o_ready  = o_ready;

    hicore_flush_queue #(.DW(8), .DP(4), .LOGDP(2), .BYPASS(0), .AFULL_TH(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .flush(flush), .kill(kill),
        .count(cnt0), .almost_full(af0));
    hicore_flush_queue #(.DW(8), .DP(8), .LOGDP(3), .BYPASS(1), .AFULL_TH(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .flush(flush), .kill(kill),
        .count(cnt1), .almost_full(af1));
    hicore_flush_queue #(.DW(8), .DP(8), .LOGDP(3), .BYPASS(0), .AFULL_TH(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(flush), .kill(kill),
        .count(cnt2), .almost_full(af2));

    logic       a_ov [3];
    logic       a_ir [3];
    logic       a_oc [3];
    logic       a_af [3];
    logic [7:0] a_info [3];
    logic [3:0] a_cnt [3];

    assign a_ov[0] = bus0.o_valid;  assign a_ov[1] = bus1.o_valid;  assign a_ov[2] = bus2.o_valid;
    assign a_ir[0] = bus0.i_ready;  assign a_ir[1] = bus1.i_ready;  assign a_ir[2] = bus2.i_ready;
    assign a_oc[0] = bus0.o_cancel; assign a_oc[1] = bus1.o_cancel; assign a_oc[2] = bus2.o_cancel;
    assign a_info[0] = bus0.o_info; assign a_info[1] = bus1.o_info; assign a_info[2] = bus2.o_info;
    assign a_af[0] = af0;           assign a_af[1] = af1;           assign a_af[2] = af2;
    assign a_cnt[0] = {1'b0, cnt0}; assign a_cnt[1] = cnt1;         assign a_cnt[2] = cnt2;

    function automatic int dp_of(input int k);
        return (k == 0) ? 4 : 8;
    endfunction
    function automatic int th_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 6 : 5);
    endfunction
    function automatic bit byp_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 50)
                $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: per configuration, an ordered list of resident entries (index 0 = head).
    logic [7:0] m_info [3][64];
    bit         m_can  [3][64];
    int         m_n    [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) m_n[k] = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin : upd
                int n;
                bit emp, byp, ov, wen, ren;
                n   = m_n[k];
                emp = (n == 0);
                byp = byp_of(k) && emp && !kill;
                ov  = byp ? i_valid : !emp;
                wen = i_valid && (n < dp_of(k));
                ren = ov && o_ready;
                if (kill) begin
                    n = 0;
                end else begin
                    if (ren && !emp) begin
                        for (int j = 0; j < n - 1; j++) begin
                            m_info[k][j] = m_info[k][j+1];
                            m_can[k][j]  = m_can[k][j+1];
                        end
                        n--;
                    end
                    if (wen && !(byp && o_ready)) begin
                        m_info[k][n] = i_info;
                        m_can[k][n]  = i_cancel;
                        n++;
                    end
                    if (flush)
                        for (int j = 0; j < n; j++) m_can[k][j] = 1'b1;
                end
                m_n[k] = n;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin : cmp
                int n;
                bit emp, byp, e_ov;
                n    = m_n[k];
                emp  = (n == 0);
                byp  = byp_of(k) && emp && !kill;
                e_ov = byp ? i_valid : !emp;
                chk("i_ready", k, 32'(a_ir[k]), 32'(n < dp_of(k)));
                chk("o_valid", k, 32'(a_ov[k]), 32'(e_ov));
                chk("count", k, 32'(a_cnt[k]), 32'(n));
                chk("almost_full", k, 32'(a_af[k]), 32'(n >= th_of(k)));
                if (e_ov) begin
                    chk("o_info", k, 32'(a_info[k]), byp ? 32'(i_info) : 32'(m_info[k][0]));
                    chk("o_cancel", k, 32'(a_oc[k]), byp ? 32'(i_cancel | flush) : 32'(m_can[k][0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        for (int k = 0; k < 3; k++) begin
            chk({nm, "_o_valid"}, k, 32'(a_ov[k]), 32'd0);
            chk({nm, "_i_ready"}, k, 32'(a_ir[k]), 32'd1);
            chk({nm, "_count"}, k, 32'(a_cnt[k]), 32'd0);
            chk({nm, "_afull"}, k, 32'(a_af[k]), 32'd0);
            chk({nm, "_o_cancel"}, k, 32'(a_oc[k]), 32'd0);
        end
    endtask

    task automatic write3(input logic [7:0] base);
        o_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            i_valid = 1'b1; i_cancel = 1'b0; i_info = base + 8'(j);
            tick();
        end
        i_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_cancel = 1'b0; i_info = 8'h00;
        o_ready = 1'b0; flush = 1'b0; kill = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #2;
        chk_reset_outputs("reset");

        // Fill to full with the last entry tagged cancelled
        for (int j = 0; j < 4; j++) begin
            i_valid = 1'b1; i_info = 8'hA0 + 8'(j); i_cancel = (j == 3);
            tick();
            #2;
            chk("fill_count", 0, 32'(a_cnt[0]), 32'(j + 1));
            chk("fill_afull", 0, 32'(a_af[0]), 32'(j >= 2));
        end
        i_info = 8'hEE; i_cancel = 1'b0;
        chk("full_i_ready", 0, 32'(a_ir[0]), 32'd0);
        tick(); tick();
        #2;
        chk("full_hold_count", 0, 32'(a_cnt[0]), 32'd4);
        i_valid = 1'b0; o_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_info", 0, 32'(a_info[0]), 32'hA0 + 32'(j));
            chk("drain_cancel", 0, 32'(a_oc[0]), 32'(j == 3));
            tick();
            #2;
        end
        chk("drained_o_valid", 0, 32'(a_ov[0]), 32'd0);
        repeat (4) tick();

        // Back-to-back stream across pointer wrap
        o_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            i_valid = 1'b1; i_info = 8'h10 + 8'(j);
            if (j == 2) o_ready = 1'b1;
            tick();
            #2;
            if (j >= 1) chk("stream_count", 2, 32'(a_cnt[2]), 32'd2);
        end
        i_valid = 1'b0;
        repeat (4) tick();

        // Soft flush with three resident entries plus a same-cycle write
        write3(8'h30);
        i_valid = 1'b1; i_info = 8'h33; flush = 1'b1;
        #2;
        chk("flush_cycle_cancel", 0, 32'(a_oc[0]), 32'd0);
        tick();
        flush = 1'b0; i_valid = 1'b0;
        #2;
        chk("flush_count", 0, 32'(a_cnt[0]), 32'd4);
        o_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("flush_drain_cancel", 0, 32'(a_oc[0]), 32'd1);
            chk("flush_drain_info", 0, 32'(a_info[0]), 32'h30 + 32'(j));
            tick();
            #2;
        end
        repeat (2) tick();

        // Hard kill together with flush, a write and a read
        write3(8'h40);
        i_valid = 1'b1; i_info = 8'h43; o_ready = 1'b1; kill = 1'b1; flush = 1'b1;
        tick();
        kill = 1'b0; flush = 1'b0; i_valid = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("kill_count", k, 32'(a_cnt[k]), 32'd0);
            chk("kill_o_valid", k, 32'(a_ov[k]), 32'd0);
            chk("kill_i_ready", k, 32'(a_ir[k]), 32'd1);
        end

        // Bypass on an empty queue, consumed and then stalled
        i_valid = 1'b1; o_ready = 1'b1; i_info = 8'h5A; i_cancel = 1'b0;
        #2;
        chk("bypass_o_valid", 1, 32'(a_ov[1]), 32'd1);
        chk("bypass_o_info", 1, 32'(a_info[1]), 32'h5A);
        tick();
        i_valid = 1'b0;
        #2;
        chk("bypass_count", 1, 32'(a_cnt[1]), 32'd0);
        repeat (2) tick();
        i_valid = 1'b1; o_ready = 1'b0; i_info = 8'h5A;
        tick();
        i_valid = 1'b0;
        #2;
        chk("bypass_stall_count", 1, 32'(a_cnt[1]), 32'd1);
        chk("bypass_stall_info", 1, 32'(a_info[1]), 32'h5A);
        o_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset mid-stream
        write3(8'h60);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic with phases of light and heavy back-pressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit heavy;
            heavy    = ((cyc / 150) % 2) == 1;
            i_valid  = ($urandom_range(0, 3) != 0);
            o_ready  = heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            i_cancel = ($urandom_range(0, 3) == 0);
            i_info   = 8'($urandom_range(0, 255));
            flush    = ($urandom_range(0, 15) == 0);
            kill     = ($urandom_range(0, 39) == 0);
            tick();
        end
        i_valid = 1'b0; flush = 1'b0; kill = 1'b0; o_ready = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
